logic_pipe: RTL

LOGIC_PIPE -- requirements
Module: logic_pipe

---
 rtl/logic_pipe.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/logic_pipe.sv
// ---------------------------------------------------------------------------
// logic_pipe
//
// A bitwise three-operand logic unit followed by a small result FIFO.
// Each accepted operand set (a, b, c, mode) produces one WIDTH-bit result.
// Results are buffered and leave in acceptance order through a registered
// valid/ready output.
//
// Operations (bitwise, no carries):
//   mode 00 : a & (b | c)
//   mode 01 : a & b
//   mode 10 : a | (b & c)
//   mode 11 : a ^ b ^ c
//
// Parameters
//   WIDTH : operand / result width (1..64)
//   DEPTH : result buffer entries (2..16, power of two)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand set presented
//   in_ready   out  block can accept an operand set (registered, = !full)
//   a, b, c    in   operands, WIDTH bits each
//   mode       in   operation select, sampled with the operands
//   out_valid  out  q holds a valid result
//   out_ready  in   consumer takes q this cycle
//   q          out  result at buffer head (holds last value when empty)
//   level      out  current buffer occupancy, 0..DEPTH
//   txn_count  out  16-bit saturating count of output pops
//                   (present only when LOGIC_PIPE_STATS_EN is defined)
//
// Optional feature macro: LOGIC_PIPE_STATS_EN
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both 1. A producer holding valid keeps its payload
// stable until the transfer; ready never depends combinationally on valid.
// Here in_ready and out_valid/q are registers, so neither side of the block
// has a combinational path from the other side's handshake inputs.
// ---------------------------------------------------------------------------
module logic_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [WIDTH-1:0]         c,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         q,
    output logic [$clog2(DEPTH):0]   level
`ifdef LOGIC_PIPE_STATS_EN
    ,
    output logic [15:0]              txn_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [LW-1:0]    level_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] q_r;

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] result;
    logic [LW-1:0]    level_next;
    logic [LW-1:0]    held_after_pop;
    logic [PW-1:0]    rd_ptr_next;
    logic [PW-1:0]    wr_ptr_next;
    logic [WIDTH-1:0] q_next;

    assign push = in_valid && in_ready_r;
    assign pop  = out_valid_r && out_ready;

    // -----------------------------------------------------------------------
    // Operation unit
    // -----------------------------------------------------------------------
    always_comb begin
        result = '0;
        case (mode)
            2'b00:   result = a & (b | c);
            2'b01:   result = a & b;
            2'b10:   result = a | (b & c);
            2'b11:   result = a ^ b ^ c;
            default: result = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state computation
    // -----------------------------------------------------------------------
    always_comb begin
        level_next     = level_r;
        rd_ptr_next    = rd_ptr;
        wr_ptr_next    = wr_ptr;
        held_after_pop = level_r;
        q_next         = q_r;

        if (push && !pop) begin
            level_next = level_r + LEVEL_ONE;
        end else if (!push && pop) begin
            level_next = level_r - LEVEL_ONE;
        end

        // Pointers are PW bits wide and DEPTH is a power of two, so the
        // increment wraps modulo DEPTH on its own.
        if (pop) begin
            rd_ptr_next    = rd_ptr + PTR_ONE;
            held_after_pop = level_r - LEVEL_ONE;
        end
        if (push) begin
            wr_ptr_next = wr_ptr + PTR_ONE;
        end

        // q is a registered copy of the head entry. If older entries remain
        // after this edge's pop, the new head is already in memory. If the
        // buffer would otherwise go empty, an incoming result bypasses
        // straight to q so it is visible one cycle after acceptance. With
        // nothing left and nothing arriving, q keeps its last value.
        if (held_after_pop != '0) begin
            q_next = mem[rd_ptr_next];
        end else if (push) begin
            q_next = result;
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level_r     <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            q_r         <= '0;
        end else begin
            rd_ptr      <= rd_ptr_next;
            wr_ptr      <= wr_ptr_next;
            level_r     <= level_next;
            // Registered !full: a pop at full frees a slot but in_ready only
            // rises on the following cycle.
            in_ready_r  <= (level_next != LEVEL_FULL);
            out_valid_r <= (level_next != '0);
            q_r         <= q_next;
        end
    end

    // -----------------------------------------------------------------------
    // Result storage. Not reset: reset empties the buffer through the
    // pointers and level, so stale contents can never be read back.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= result;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign q         = q_r;
    assign level     = level_r;

`ifdef LOGIC_PIPE_STATS_EN
    // -----------------------------------------------------------------------
    // Saturating pop counter
    // -----------------------------------------------------------------------
    logic [15:0] txn_count_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count_r <= '0;
        end else if (pop && (txn_count_r != 16'hFFFF)) begin
            txn_count_r <= txn_count_r + 16'd1;
        end
    end

    assign txn_count = txn_count_r;
`endif

endmodule
